conf_reg_responder: RTL and testbench

Responder end of the packet-driven configuration interface. Accepts single-cycle read/write strobes from the packet demultiplexer's configuration port, serves a 128-bit register map and drives the per-PE configuring-enable vector. Sequences each PE's release from configuration: a delayed start pulse after its enable bit falls. Sits between the packet processing top and the PE array, alongside the DMA/DRA engines.

---
 rtl/conf_reg_pkg.sv | 25 ++
 rtl/conf_pe_release_seq.sv | 57 +++++
 rtl/conf_reg_responder.sv | 129 ++++++++++++
 tb/tb_conf_reg_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_reg_pkg.sv
// conf_reg_pkg: shared constants and types for the configuration responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conf_reg_pkg;

  // Word addresses of the register map
  localparam logic [15:0] ADDR_CTRL      = 16'h0000;
  localparam logic [15:0] ADDR_CMD       = 16'h0001;
  localparam logic [15:0] ADDR_VERSION   = 16'h0002;
  localparam logic [15:0] ADDR_SCRATCH   = 16'h0003;
  localparam logic [15:0] ADDR_BOOT_BASE = 16'h0010;
  localparam logic [15:0] ADDR_STATS     = 16'h0020;

  // CMD register bit positions
  localparam int CMD_CLR_STATS = 0;
  localparam int CMD_RECONF    = 1;

  // Per-PE release sequencer states
  typedef enum logic [1:0] {
    CONF = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/conf_pe_release_seq.sv
// conf_pe_release_seq: releases one PE from configuration with a delayed start pulse.
// Latency: start pulse hold_cycles cycles after the enable bit is first seen low.
// Backpressure: none; follows the enable level every cycle.
module conf_pe_release_seq
  import conf_reg_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_hold_cycles,
  output logic       o_start
);

  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // State and hold counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CONF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enable high always means configuring; being in CONF with enable low
  // can only follow a 1->0 fall, since the enable resets to 1. A rise
  // seen in the final HOLD cycle aborts the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_start = 1'b0;
    if (i_en) begin
      state_d = CONF;
    end else begin
      case (state_q)
        CONF: begin
          state_d = HOLD;
          cnt_d   = i_hold_cycles - 8'd1;
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            o_start = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = CONF;
      endcase
    end
  end

endmodule

// File: rtl/conf_reg_responder.sv
// conf_reg_responder: configuration register map responder and per-PE release control.
// Latency: reads registered (data 1 cycle after strobe); writes commit at the strobe edge.
// Backpressure: none; one access accepted every cycle, never stalls.
// Optional feature macro CONF_STATS_EN: builds packet stats counters and the STATS register.
module conf_reg_responder
  import conf_reg_pkg::*;
#(
  parameter int          NUM_PE      = 4,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [31:0] VERSION     = 32'h2024_0221
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_conf_rden,
  input  logic              i_conf_wren,
  input  logic [15:0]       i_conf_addr,
  input  logic [127:0]      i_conf_wdata,
  output logic [127:0]      o_conf_rdata,
  output logic              o_conf_rvalid,
  output logic [NUM_PE-1:0] o_conf_en,
  output logic [NUM_PE-1:0] o_pe_start,
  input  logic              i_pkt_in_pulse,
  input  logic              i_pkt_out_pulse
);

  logic [NUM_PE-1:0] ctrl_q;
  logic [127:0]      scratch_q;
  logic [31:0]       boot_q [NUM_PE];
  logic [127:0]      stats_word;
  logic [127:0]      rd_word;
  logic              wr_ctrl;
  logic              wr_cmd;
  logic              wr_scratch;

  assign wr_ctrl    = i_conf_wren && (i_conf_addr == ADDR_CTRL);
  assign wr_cmd     = i_conf_wren && (i_conf_addr == ADDR_CMD);
  assign wr_scratch = i_conf_wren && (i_conf_addr == ADDR_SCRATCH);

  // CTRL: direct write, or forced back to all-configuring by CMD
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q <= '1;
    end else if (wr_ctrl) begin
      ctrl_q <= i_conf_wdata[NUM_PE-1:0];
    end else if (wr_cmd && i_conf_wdata[CMD_RECONF]) begin
      ctrl_q <= '1;
    end
  end

  assign o_conf_en = ctrl_q;

  // SCRATCH and BOOT_ADDR storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scratch_q <= '0;
      for (int i = 0; i < NUM_PE; i++) boot_q[i] <= '0;
    end else begin
      if (wr_scratch) scratch_q <= i_conf_wdata;
      if (i_conf_wren) begin
        for (int i = 0; i < NUM_PE; i++) begin
          if (i_conf_addr == ADDR_BOOT_BASE + 16'(i)) boot_q[i] <= i_conf_wdata[31:0];
        end
      end
    end
  end

`ifdef CONF_STATS_EN
  logic [63:0] pkt_in_cnt_q;
  logic [63:0] pkt_out_cnt_q;
  logic        stats_clr;

  assign stats_clr = wr_cmd && i_conf_wdata[CMD_CLR_STATS];

  // Packet counters; a clear overrides a same-cycle increment
  always_ff @(posedge i_clk) begin
    if (i_rst || stats_clr) begin
      pkt_in_cnt_q  <= '0;
      pkt_out_cnt_q <= '0;
    end else begin
      pkt_in_cnt_q  <= pkt_in_cnt_q + 64'(i_pkt_in_pulse);
      pkt_out_cnt_q <= pkt_out_cnt_q + 64'(i_pkt_out_pulse);
    end
  end

  assign stats_word = {pkt_out_cnt_q, pkt_in_cnt_q};
`else
  logic unused_pkt;
  assign unused_pkt = i_pkt_in_pulse | i_pkt_out_pulse;
  assign stats_word = '0;
`endif

  // Read mux over current (pre-write) register contents
  always_comb begin
    rd_word = '0;
    case (i_conf_addr)
      ADDR_CTRL:    rd_word[NUM_PE-1:0] = ctrl_q;
      ADDR_VERSION: rd_word[47:0] = {8'(HOLD_CYCLES), 8'(NUM_PE), VERSION};
      ADDR_SCRATCH: rd_word = scratch_q;
      ADDR_STATS:   rd_word = stats_word;
      default:      rd_word = '0;
    endcase
    for (int i = 0; i < NUM_PE; i++) begin
      if (i_conf_addr == ADDR_BOOT_BASE + 16'(i)) rd_word[31:0] = boot_q[i];
    end
  end

  // Registered read response; data holds until the next read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_conf_rvalid <= 1'b0;
      o_conf_rdata  <= '0;
    end else begin
      o_conf_rvalid <= i_conf_rden;
      if (i_conf_rden) o_conf_rdata <= rd_word;
    end
  end

  // One release sequencer per PE
  for (genvar g = 0; g < NUM_PE; g++) begin : g_seq
    conf_pe_release_seq u_seq (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_en          (ctrl_q[g]),
      .i_hold_cycles (8'(HOLD_CYCLES)),
      .o_start       (o_pe_start[g])
    );
  end

endmodule

// File: tb/tb_conf_reg_responder.sv
// tb_conf_reg_responder: randomized bench with a transaction-level register/release model.
// Latency: checks 1-cycle reads and the hold-to-start timing.
// Backpressure: n/a (DUT never stalls).
module tb_conf_reg_responder;

  localparam int H = 16;

  logic         clk, rst, rden, wren, pin, pout;
  logic [15:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         rvalid;
  logic [3:0]   conf_en, pe_start;

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;

  // Reference model: register contents plus the cycle at which each PE's
  // start pulse is due (-1 when none is pending).
  logic [3:0]   m_ctrl;
  logic [127:0] m_scratch;
  logic [31:0]  m_boot [4];
  logic [63:0]  m_in, m_out;
  longint       pend [4];
  logic [127:0] exp_rdata;
  logic         exp_rvalid;

  conf_reg_responder #(
    .NUM_PE      (4),
    .HOLD_CYCLES (H),
    .VERSION     (32'h2024_0221)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_conf_rden     (rden),
    .i_conf_wren     (wren),
    .i_conf_addr     (addr),
    .i_conf_wdata    (wdata),
    .o_conf_rdata    (rdata),
    .o_conf_rvalid   (rvalid),
    .o_conf_en       (conf_en),
    .o_pe_start      (pe_start),
    .i_pkt_in_pulse  (pin),
    .i_pkt_out_pulse (pout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_ctrl = 4'hF;
    m_scratch = '0;
    for (int i = 0; i < 4; i++) begin
      m_boot[i] = '0;
      pend[i] = -1;
    end
    m_in = '0;
    m_out = '0;
    exp_rdata = '0;
    exp_rvalid = 1'b0;
  endtask

  // A bit dropping 1->0 schedules a pulse H+1 cycles after the write cycle;
  // a bit set to 1 cancels anything pending.
  task automatic apply_ctrl(input logic [3:0] nv);
    for (int i = 0; i < 4; i++) begin
      if (m_ctrl[i] && !nv[i]) pend[i] = cyc + 1 + H;
      if (nv[i]) pend[i] = -1;
    end
    m_ctrl = nv;
  endtask

  function automatic logic [127:0] m_read(input logic [15:0] a);
    logic [127:0] v;
    int idx;
    v = '0;
    idx = int'(a) - 16;
    if (a == 16'h0000) v = {124'd0, m_ctrl};
    else if (a == 16'h0002) v = {80'd0, 8'd16, 8'd4, 32'h2024_0221};
    else if (a == 16'h0003) v = m_scratch;
    else if (idx >= 0 && idx < 4) v = {96'd0, m_boot[idx]};
    else if (a == 16'h0020) begin
`ifdef CONF_STATS_EN
      v = {m_out, m_in};
`else
      v = '0;
`endif
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_start();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (pend[i] == cyc);
    return e;
  endfunction

  // Drive one access cycle, advance the model, and step past the clock edge.
  task automatic cycle_io(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [127:0] wd, input logic pi, input logic po);
    int idx;
    rden = rd; wren = wr; addr = a; wdata = wd; pin = pi; pout = po;
    idx = int'(a) - 16;
    if (rd) exp_rdata = m_read(a);
    exp_rvalid = rd;
    if (wr) begin
      if (a == 16'h0000) apply_ctrl(wd[3:0]);
      else if (a == 16'h0001 && wd[1]) apply_ctrl(4'hF);
      else if (a == 16'h0003) m_scratch = wd;
      else if (idx >= 0 && idx < 4) m_boot[idx] = wd[31:0];
    end
    if (wr && a == 16'h0001 && wd[0]) begin
      m_in = '0;
      m_out = '0;
    end else begin
      m_in = m_in + 64'(pi);
      m_out = m_out + 64'(po);
    end
    @(posedge clk); #1; cyc++;
    rden = 1'b0; wren = 1'b0; pin = 1'b0; pout = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rden = 1'b1; wren = 1'b0; addr = 16'h0000; wdata = '0; pin = 1'b0; pout = 1'b0;
    @(posedge clk); #1; cyc++;
    rden = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    model_reset();
    n_cmp++; if (conf_en !== 4'hF) begin n_fail++; $display("FAIL reset_conf_en got=%h want=f", conf_en); end
    n_cmp++; if (pe_start !== 4'h0) begin n_fail++; $display("FAIL reset_pe_start got=%h want=0", pe_start); end
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    cycle_io(1'b1, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL ctrl_read_rvalid got=%b want=1", rvalid); end
    n_cmp++; if (rdata !== 128'hF) begin n_fail++; $display("FAIL ctrl_read_rdata got=%h want=f", rdata); end
    cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got=%b want=0", rvalid); end
    n_cmp++; if (rdata !== 128'hF) begin n_fail++; $display("FAIL rdata_hold got=%h want=f", rdata); end
  endtask

  task automatic test_scratch_rw();
    logic [127:0] pat;
    pat = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    cycle_io(1'b1, 1'b1, 16'h0003, pat, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL scratch_same_cycle got=%h want=0", rdata); end
    cycle_io(1'b1, 1'b0, 16'h0003, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== pat) begin n_fail++; $display("FAIL scratch_readback got=%h want=%h", rdata, pat); end
  endtask

  task automatic test_boot_version();
    cycle_io(1'b0, 1'b1, 16'h0012, 128'hFFFF_0000_8000_0000, 1'b0, 1'b0);
    cycle_io(1'b1, 1'b0, 16'h0012, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'h8000_0000) begin n_fail++; $display("FAIL boot2_readback got=%h want=80000000", rdata); end
    cycle_io(1'b1, 1'b0, 16'h0014, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL boot_out_of_range got=%h want=0", rdata); end
    cycle_io(1'b1, 1'b0, 16'h7FFF, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL unmapped_read got=%h want=0", rdata); end
    cycle_io(1'b1, 1'b0, 16'h0002, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'h10_04_2024_0221) begin n_fail++; $display("FAIL version got=%h want=100420240221", rdata); end
    cycle_io(1'b1, 1'b0, 16'h0001, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL cmd_reads_zero got=%h want=0", rdata); end
  endtask

  task automatic test_release_basic();
    longint n0;
    longint seen;
    int     pulses;
    seen = -1;
    pulses = 0;
    n0 = cyc;
    cycle_io(1'b0, 1'b1, 16'h0000, 128'hE, 1'b0, 1'b0);
    n_cmp++; if (conf_en !== 4'hE) begin n_fail++; $display("FAIL release_conf_en got=%h want=e", conf_en); end
    for (int k = 0; k < 22; k++) begin
      n_cmp++; if (pe_start !== exp_start()) begin n_fail++; $display("FAIL release_pulse cyc=%0d got=%b want=%b", cyc, pe_start, exp_start()); end
      if (pe_start[0] === 1'b1) begin pulses++; seen = cyc; end
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    n_cmp++; if (pulses != 1 || seen != n0 + 17) begin n_fail++; $display("FAIL release_timing got=%0d pulses at offset %0d want=1 at 17", pulses, seen - n0); end
    cycle_io(1'b0, 1'b1, 16'h0000, 128'hF, 1'b0, 1'b0);
    n_cmp++; if (conf_en !== 4'hF) begin n_fail++; $display("FAIL reconf_conf_en got=%h want=f", conf_en); end
  endtask

  task automatic test_release_abort();
    int bad;
    bad = 0;
    cycle_io(1'b0, 1'b1, 16'h0000, 128'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (pe_start !== 4'h0) bad++;
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    cycle_io(1'b0, 1'b1, 16'h0000, 128'hF, 1'b0, 1'b0);
    for (int k = 0; k < 25; k++) begin
      if (pe_start !== 4'h0) bad++;
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL abort_5cyc got=%0d pulse cycles want=0", bad); end
    n_cmp++; if (conf_en !== 4'hF) begin n_fail++; $display("FAIL abort_conf_en got=%h want=f", conf_en); end
    // Re-enable in the last cycle of the hold window still suppresses the pulse
    bad = 0;
    cycle_io(1'b0, 1'b1, 16'h0000, 128'h0, 1'b0, 1'b0);
    for (int k = 0; k < H - 1; k++) begin
      if (pe_start !== 4'h0) bad++;
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    cycle_io(1'b0, 1'b1, 16'h0001, 128'h2, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (pe_start !== 4'h0) bad++;
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL abort_last_cycle got=%0d pulse cycles want=0", bad); end
    n_cmp++; if (conf_en !== 4'hF) begin n_fail++; $display("FAIL cmd_reconf got=%h want=f", conf_en); end
  endtask

  task automatic test_stats();
    logic [127:0] want;
    cycle_io(1'b0, 1'b1, 16'h0001, 128'h1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b1, (k < 3));
`ifdef CONF_STATS_EN
    want = {64'd3, 64'd10};
`else
    want = '0;
`endif
    cycle_io(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== want) begin n_fail++; $display("FAIL stats_count got=%h want=%h", rdata, want); end
    cycle_io(1'b0, 1'b1, 16'h0001, 128'h1, 1'b1, 1'b1);
    cycle_io(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL stats_clear_wins got=%h want=0", rdata); end
    cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b0);
    cycle_io(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b1);
`ifdef CONF_STATS_EN
    want = {64'd0, 64'd1};
`else
    want = '0;
`endif
    n_cmp++; if (rdata !== want) begin n_fail++; $display("FAIL stats_next_cycle got=%h want=%h", rdata, want); end
  endtask

  task automatic test_random_access();
    for (int k = 0; k < 300; k++) begin
      logic [15:0]  a;
      logic [127:0] wd;
      int           sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3: a = 16'(sel);
        4, 5, 6, 7, 8: a = 16'h0010 + 16'(sel - 4);
        9: a = 16'h0020;
        10: a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      wd = {$urandom, $urandom, $urandom, $urandom};
      cycle_io(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, wd,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++; if (rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rand_rvalid cyc=%0d got=%b want=%b", cyc, rvalid, exp_rvalid); end
      n_cmp++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, rdata, exp_rdata); end
      n_cmp++; if (conf_en !== m_ctrl) begin n_fail++; $display("FAIL rand_conf_en cyc=%0d got=%h want=%h", cyc, conf_en, m_ctrl); end
      n_cmp++; if (pe_start !== exp_start()) begin n_fail++; $display("FAIL rand_pe_start cyc=%0d got=%b want=%b", cyc, pe_start, exp_start()); end
    end
  endtask

  task automatic test_release_random();
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r < 6) cycle_io(1'b0, 1'b1, 16'h0000, 128'($urandom_range(0, 15)), 1'b0, 1'b0);
      else if (r == 6) cycle_io(1'b0, 1'b1, 16'h0001, 128'h2, 1'b0, 1'b0);
      else cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
      n_cmp++; if (conf_en !== m_ctrl) begin n_fail++; $display("FAIL seq_conf_en cyc=%0d got=%h want=%h", cyc, conf_en, m_ctrl); end
      n_cmp++; if (pe_start !== exp_start()) begin n_fail++; $display("FAIL seq_pe_start cyc=%0d got=%b want=%b", cyc, pe_start, exp_start()); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    cycle_io(1'b0, 1'b1, 16'h0000, 128'hF, 1'b0, 1'b0);
    cycle_io(1'b0, 1'b1, 16'h0000, 128'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b0);
    rst = 1'b1; rden = 1'b1; addr = 16'h0003;
    @(posedge clk); #1; cyc++;
    rst = 1'b0; rden = 1'b0;
    model_reset();
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid got=%b want=0", rvalid); end
    n_cmp++; if (conf_en !== 4'hF) begin n_fail++; $display("FAIL midreset_conf_en got=%h want=f", conf_en); end
    for (int k = 0; k < H + 4; k++) begin
      if (pe_start !== 4'h0) bad++;
      cycle_io(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL midreset_pulse got=%0d pulse cycles want=0", bad); end
    cycle_io(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL midreset_stats got=%h want=0", rdata); end
  endtask

  initial begin
    test_reset();
    test_scratch_rw();
    test_boot_version();
    test_release_basic();
    test_release_abort();
    test_stats();
    test_random_access();
    test_release_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
